// File: rtl/bus_sram_controller.sv
// Bridges a 32-bit CPU bus onto a 16-bit asynchronous SRAM, splitting word
// accesses into two big-endian halfword phases of WAIT_CYCLES clocks each.
module bus_sram_controller #(
  parameter int ADDRESS_WIDTH = 20,  // 1..30
  parameter int WAIT_CYCLES   = 1    // 1..15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     busEnable,
  input  logic [1:0]               busSize,
  input  logic                     busWrite,
  input  logic [31:0]              busAddress,
  input  logic [31:0]              busWriteData,
  output logic [31:0]              busReadData,
  output logic                     busWait,
  output logic [ADDRESS_WIDTH-1:0] sramAddress,
  output logic [15:0]              sramDataOut,
  input  logic [15:0]              sramDataIn,
  output logic                     sramChipEnable,
  output logic                     sramWriteEnable,
  output logic                     sramOutputEnable,
  output logic [1:0]               sramByteEnable
);

  typedef enum logic [1:0] {IDLE, PHASE_HIGH, PHASE_LOW, DONE} stateType;

  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

  stateType                 state;
  logic [3:0]               count;
  logic                     reqWord;
  logic                     reqByte;
  logic                     reqWrite;
  logic                     reqByteLsb;
  logic [ADDRESS_WIDTH-1:0] reqHalfAddress;
  logic [31:0]              reqWriteData;
  logic [31:0]              readBuffer;

  logic acceptWord;
  logic acceptByte;
  logic endAccess;
  logic unusedAddressBits;

  // Size 2'b11 decodes as a word because only bit 1 is looked at.
  assign acceptWord = busSize[1];
  assign acceptByte = (busSize == 2'b00);
  assign unusedAddressBits = ^busAddress[31:ADDRESS_WIDTH+1];

  // An access ends either on its last phase cycle or when the bus master aborts.
  assign endAccess = (state == PHASE_HIGH || state == PHASE_LOW) &&
                     (!busEnable || (state == PHASE_LOW && count == 4'd0));

  function automatic logic [ADDRESS_WIDTH-1:0] phaseAddress(
    input logic isWord, input logic isHigh, input logic [ADDRESS_WIDTH-1:0] halfAddress);
    phaseAddress = halfAddress;
    if (isWord) phaseAddress[0] = !isHigh;
  endfunction

  function automatic logic [15:0] phaseData(
    input logic isWord, input logic isByte, input logic isHigh, input logic [31:0] data);
    if (isByte)               phaseData = {2{data[7:0]}};
    else if (isWord && isHigh) phaseData = data[31:16];
    else                      phaseData = data[15:0];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      count            <= 4'd0;
      reqWord          <= 1'b0;
      reqByte          <= 1'b0;
      reqWrite         <= 1'b0;
      reqByteLsb       <= 1'b0;
      reqHalfAddress   <= '0;
      reqWriteData     <= 32'd0;
      readBuffer       <= 32'd0;
      sramAddress      <= '0;
      sramDataOut      <= 16'd0;
      sramChipEnable   <= 1'b0;
      sramWriteEnable  <= 1'b0;
      sramOutputEnable <= 1'b0;
      sramByteEnable   <= 2'b00;
    end else begin
      // NOTE: every register here uses <= so all branches see pre-edge values.
      unique case (state)
        IDLE: if (busEnable) begin
          reqWord          <= acceptWord;
          reqByte          <= acceptByte;
          reqWrite         <= busWrite;
          reqByteLsb       <= busAddress[0];
          reqHalfAddress   <= busAddress[ADDRESS_WIDTH:1];
          reqWriteData     <= busWriteData;
          state            <= acceptWord ? PHASE_HIGH : PHASE_LOW;
          count            <= RELOAD;
          sramChipEnable   <= 1'b1;
          sramWriteEnable  <= busWrite;
          sramOutputEnable <= !busWrite;
          sramByteEnable   <= acceptByte ? (busAddress[0] ? 2'b01 : 2'b10) : 2'b11;
          sramAddress      <= phaseAddress(acceptWord, 1'b1, busAddress[ADDRESS_WIDTH:1]);
          sramDataOut      <= phaseData(acceptWord, acceptByte, 1'b1, busWriteData);
        end
        PHASE_HIGH: begin
          if (!busEnable) begin
            state <= IDLE;
          end else if (count == 4'd0) begin
            if (!reqWrite) readBuffer[31:16] <= sramDataIn;
            state       <= PHASE_LOW;
            count       <= RELOAD;
            sramAddress <= phaseAddress(1'b1, 1'b0, reqHalfAddress);
            sramDataOut <= phaseData(1'b1, 1'b0, 1'b0, reqWriteData);
          end else begin
            count <= count - 4'd1;
          end
        end
        PHASE_LOW: begin
          if (!busEnable) begin
            state <= IDLE;
          end else if (count == 4'd0) begin
            if (!reqWrite) readBuffer[15:0] <= sramDataIn;
            state <= DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      // Overrides the strobe values assigned above when the access finishes.
      if (endAccess) begin
        sramChipEnable   <= 1'b0;
        sramWriteEnable  <= 1'b0;
        sramOutputEnable <= 1'b0;
        sramByteEnable   <= 2'b00;
      end
    end
  end

  assign busWait = busEnable && (state != DONE);

  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    busReadData = 32'd0;
    if (state == DONE) begin
      if (reqWord)      busReadData = readBuffer;
      else if (reqByte) busReadData = {24'd0, reqByteLsb ? readBuffer[7:0] : readBuffer[15:8]};
      else              busReadData = {16'd0, readBuffer[15:0]};
    end
  end

endmodule
